// File: rtl/stream_mem_pkg.sv
// Shared types for the stream memory responder: header layout, opcodes,
// transfer sizes, FSM states and small decode helpers.
// No ports; imported by the interface, the storage array and the top.
package stream_mem_pkg;

    localparam int stream_mem_paddr_width_gp   = 40;
    localparam int stream_mem_payload_width_gp = 8;
    localparam int stream_mem_header_width_gp  = 4 + stream_mem_paddr_width_gp + 3
                                                 + stream_mem_payload_width_gp;
    // Up to 16 beats (128 B), so the counter must be able to hold 16.
    localparam int beat_cnt_width_gp           = $clog2(17);

    typedef enum logic [3:0] {
        e_mem_rd    = 4'd0,
        e_mem_wr    = 4'd1,
        e_mem_uc_rd = 4'd2,
        e_mem_uc_wr = 4'd3
    } mem_opcode_e;

    typedef enum logic [2:0] {
        e_size_1   = 3'd0,
        e_size_2   = 3'd1,
        e_size_4   = 3'd2,
        e_size_8   = 3'd3,
        e_size_16  = 3'd4,
        e_size_32  = 3'd5,
        e_size_64  = 3'd6,
        e_size_128 = 3'd7
    } mem_size_e;

    // msg_type occupies the MSBs, payload the LSBs.
    typedef struct packed {
        logic [3:0]                               msg_type;
        logic [stream_mem_paddr_width_gp-1:0]     addr;
        mem_size_e                                size;
        logic [stream_mem_payload_width_gp-1:0]   payload;
    } stream_mem_header_s;

    typedef enum logic [2:0] {
        e_idle     = 3'd0,
        e_wr_data  = 3'd1,
        e_resp_hdr = 3'd2,
        e_rd_fetch = 3'd3,
        e_rd_send  = 3'd4
    } state_e;

    // Sub-dword sizes still move one beat.
    function automatic logic [beat_cnt_width_gp-1:0] beats_from_size(input logic [2:0] size);
        if (size < 3'd3) begin
            return beat_cnt_width_gp'(1);
        end
        return beat_cnt_width_gp'(1) << (size - 3'd3);
    endfunction

    // Byte lanes touched by a write; sub-dword writes land at addr[2:0].
    function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [2:0] offset);
        logic [7:0] lanes;
        if (size >= 3'd3) begin
            return 8'hFF;
        end
        lanes = (8'd1 << (4'd1 << size)) - 8'd1;
        return lanes << offset;
    endfunction

    function automatic logic is_write_op(input logic [3:0] op);
        return (op == e_mem_wr) || (op == e_mem_uc_wr);
    endfunction

    function automatic logic is_read_op(input logic [3:0] op);
        return (op == e_mem_rd) || (op == e_mem_uc_rd);
    endfunction

endpackage

// File: rtl/bp_stream_mem_responder_if.sv
// Command/response stream bundle between a memory requester and the responder.
// Ports: command header + write data (ready-valid), response header + read data
// (valid-yumi). slave = responder side, master = requester side.
interface bp_stream_mem_responder_if #(
    parameter int header_width_p = stream_mem_pkg::stream_mem_header_width_gp,
    parameter int data_width_p   = 64
);
    logic [header_width_p-1:0] mem_cmd_header_i;
    logic                      mem_cmd_header_v_i;
    logic                      mem_cmd_header_ready_and_o;

    logic [data_width_p-1:0]   mem_cmd_data_i;
    logic                      mem_cmd_data_v_i;
    logic                      mem_cmd_data_ready_and_o;

    logic [header_width_p-1:0] mem_resp_header_o;
    logic                      mem_resp_header_v_o;
    logic                      mem_resp_header_yumi_i;

    logic [data_width_p-1:0]   mem_resp_data_o;
    logic                      mem_resp_data_v_o;
    logic                      mem_resp_data_yumi_i;

    modport slave (
        input  mem_cmd_header_i, mem_cmd_header_v_i,
        output mem_cmd_header_ready_and_o,
        input  mem_cmd_data_i, mem_cmd_data_v_i,
        output mem_cmd_data_ready_and_o,
        output mem_resp_header_o, mem_resp_header_v_o,
        input  mem_resp_header_yumi_i,
        output mem_resp_data_o, mem_resp_data_v_o,
        input  mem_resp_data_yumi_i
    );

    modport master (
        output mem_cmd_header_i, mem_cmd_header_v_i,
        input  mem_cmd_header_ready_and_o,
        output mem_cmd_data_i, mem_cmd_data_v_i,
        input  mem_cmd_data_ready_and_o,
        input  mem_resp_header_o, mem_resp_header_v_o,
        output mem_resp_header_yumi_i,
        input  mem_resp_data_o, mem_resp_data_v_o,
        output mem_resp_data_yumi_i
    );
endinterface

// File: rtl/bp_stream_mem_array.sv
// Backing store: single-port (1rw) array, synchronous read, byte-masked write.
// Ports: clk_i, v_i/w_i access strobes, addr_i word index, wmask_i/data_i write,
// data_o registered read data (holds until the next read). Never reset.
module bp_stream_mem_array #(
    parameter int els_p   = 256,
    parameter int width_p = 64,
    localparam int idx_w_lp  = $clog2(els_p),
    localparam int mask_w_lp = width_p / 8
) (
    input  logic                 clk_i,
    input  logic                 v_i,
    input  logic                 w_i,
    input  logic [idx_w_lp-1:0]  addr_i,
    input  logic [mask_w_lp-1:0] wmask_i,
    input  logic [width_p-1:0]   data_i,
    output logic [width_p-1:0]   data_o
);
    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                for (int b = 0; b < mask_w_lp; b++) begin
                    if (wmask_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign data_o = rdata_q;
endmodule

// File: rtl/bp_stream_mem_responder.sv
// Stream memory responder: accepts a command header (+ write beats), echoes the
// header, and streams read beats critical-word-first out of a local array.
// Ports: clk_i, reset_i (async, active-high), mem_if (slave side of the bundle).
// Optional: define BP_STREAM_MEM_BOUNDS_CHECK_EN to drop out-of-range writes and
// return all-ones read beats; otherwise indices wrap modulo mem_els_p.
module bp_stream_mem_responder
    import stream_mem_pkg::*;
#(
    parameter int paddr_width_p  = 40,
    parameter int data_width_p   = 64,
    parameter int mem_els_p      = 256,
    parameter int header_width_p = stream_mem_header_width_gp
) (
    input  logic clk_i,
    input  logic reset_i,
    bp_stream_mem_responder_if.slave mem_if
);
    localparam int idx_w_lp    = $clog2(mem_els_p);
    localparam int mask_w_lp   = data_width_p / 8;
    localparam int size_lsb_lp = stream_mem_payload_width_gp;
    localparam int addr_lsb_lp = size_lsb_lp + 3;
    localparam int type_lsb_lp = addr_lsb_lp + paddr_width_p;

    state_e                        state_q, state_d;
    logic [header_width_p-1:0]     hdr_q, hdr_d;
    logic [idx_w_lp-1:0]           idx_q, idx_d;
    logic [beat_cnt_width_gp-1:0]  beats_q, beats_d;

    // Header fields of the incoming command and of the latched one.
    logic [3:0]                cmd_type, hq_type;
    logic [2:0]                cmd_size, hq_size;
    logic [paddr_width_p-1:0]  cmd_addr, hq_addr;

    assign cmd_type = mem_if.mem_cmd_header_i[type_lsb_lp +: 4];
    assign cmd_size = mem_if.mem_cmd_header_i[size_lsb_lp +: 3];
    assign cmd_addr = mem_if.mem_cmd_header_i[addr_lsb_lp +: paddr_width_p];
    assign hq_type  = hdr_q[type_lsb_lp +: 4];
    assign hq_size  = hdr_q[size_lsb_lp +: 3];
    assign hq_addr  = hdr_q[addr_lsb_lp +: paddr_width_p];

    // Payload and unindexed address bits pass through untouched.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{hdr_q, mem_if.mem_cmd_header_i, cmd_addr, hq_addr};

    logic cmd_hdr_rdy, cmd_data_rdy, resp_hdr_v, resp_data_v;
    logic mem_v, mem_w;
    logic cmd_hdr_hs, cmd_data_hs, resp_hdr_hs, resp_data_hs;
    logic last_beat;
    logic oob;

    // Yumi only counts while the matching valid is up.
    assign cmd_hdr_hs   = cmd_hdr_rdy  & mem_if.mem_cmd_header_v_i;
    assign cmd_data_hs  = cmd_data_rdy & mem_if.mem_cmd_data_v_i;
    assign resp_hdr_hs  = resp_hdr_v   & mem_if.mem_resp_header_yumi_i;
    assign resp_data_hs = resp_data_v  & mem_if.mem_resp_data_yumi_i;
    assign last_beat    = (beats_q == beat_cnt_width_gp'(1));

`ifdef BP_STREAM_MEM_BOUNDS_CHECK_EN
    localparam logic [paddr_width_p-1:0] mem_bytes_lp = paddr_width_p'(mem_els_p * 8);
    assign oob = (hq_addr >= mem_bytes_lp);
`else
    assign oob = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_idle: begin
                if (cmd_hdr_hs) begin
                    state_d = is_write_op(cmd_type) ? e_wr_data : e_resp_hdr;
                end
            end
            e_wr_data: begin
                if (cmd_data_hs && last_beat) begin
                    state_d = e_resp_hdr;
                end
            end
            e_resp_hdr: begin
                if (resp_hdr_hs) begin
                    state_d = is_read_op(hq_type) ? e_rd_fetch : e_idle;
                end
            end
            e_rd_fetch: state_d = e_rd_send;
            e_rd_send: begin
                if (resp_data_hs) begin
                    state_d = last_beat ? e_idle : e_rd_fetch;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_hdr_rdy  = 1'b0;
        cmd_data_rdy = 1'b0;
        resp_hdr_v   = 1'b0;
        resp_data_v  = 1'b0;
        mem_v        = 1'b0;
        mem_w        = 1'b0;
        unique case (state_q)
            e_idle:     cmd_hdr_rdy = 1'b1;
            e_wr_data: begin
                cmd_data_rdy = 1'b1;
                mem_v        = mem_if.mem_cmd_data_v_i;
                mem_w        = 1'b1;
            end
            e_resp_hdr: resp_hdr_v  = 1'b1;
            e_rd_fetch: mem_v       = 1'b1;
            e_rd_send:  resp_data_v = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Transaction datapath ----------------
    // Advance wraps inside the size-aligned block so a burst that starts
    // mid-line returns the critical word first and then wraps around.
    logic [idx_w_lp-1:0] blk_mask, idx_next;
    assign blk_mask = idx_w_lp'(beats_from_size(hq_size) - beat_cnt_width_gp'(1));
    assign idx_next = (idx_q & ~blk_mask) | ((idx_q + idx_w_lp'(1)) & blk_mask);

    always_comb begin
        hdr_d   = hdr_q;
        idx_d   = idx_q;
        beats_d = beats_q;
        if (cmd_hdr_hs) begin
            hdr_d   = mem_if.mem_cmd_header_i;
            idx_d   = cmd_addr[3 +: idx_w_lp];
            beats_d = beats_from_size(cmd_size);
        end else if (cmd_data_hs || resp_data_hs) begin
            idx_d   = idx_next;
            beats_d = beats_q - beat_cnt_width_gp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hdr_q   <= '0;
            idx_q   <= '0;
            beats_q <= '0;
        end else begin
            hdr_q   <= hdr_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
        end
    end

    // ---------------- Storage ----------------
    // Sub-dword write data arrives in the low lanes; shift it onto addr[2:0].
    logic [mask_w_lp-1:0]    mem_wmask;
    logic [data_width_p-1:0] mem_wdata, mem_rdata;

    assign mem_wmask = oob ? '0 : mask_w_lp'(byte_mask(hq_size, hq_addr[2:0]));
    assign mem_wdata = (hq_size < 3'd3)
                     ? (mem_if.mem_cmd_data_i << {hq_addr[2:0], 3'b000})
                     : mem_if.mem_cmd_data_i;

    bp_stream_mem_array #(
        .els_p   (mem_els_p),
        .width_p (data_width_p)
    ) mem_array (
        .clk_i   (clk_i),
        .v_i     (mem_v),
        .w_i     (mem_w),
        .addr_i  (idx_q),
        .wmask_i (mem_wmask),
        .data_i  (mem_wdata),
        .data_o  (mem_rdata)
    );

    // ---------------- Interface drive ----------------
    assign mem_if.mem_cmd_header_ready_and_o = cmd_hdr_rdy;
    assign mem_if.mem_cmd_data_ready_and_o   = cmd_data_rdy;
    assign mem_if.mem_resp_header_o          = hdr_q;
    assign mem_if.mem_resp_header_v_o        = resp_hdr_v;
    assign mem_if.mem_resp_data_o            = oob ? '1 : mem_rdata;
    assign mem_if.mem_resp_data_v_o          = resp_data_v;

endmodule

// File: doc/bp_stream_mem_responder.md
BP_STREAM_MEM_RESPONDER -- requirements
Module: bp_stream_mem_responder

Interface
REQ-001 SHALL have parameter paddr_width_p, default 40, physical address width.
REQ-002 SHALL have parameter data_width_p, default 64, stream beat width (one dword).
REQ-003 SHALL have parameter mem_els_p, default 256, dword entries in backing store.
REQ-004 SHALL have parameter header_width_p, default from stream_mem_pkg, header width.
REQ-005 clk_i  input  1  single clock.
REQ-006 reset_i  input  1  reset; asynchronous, active-high.
REQ-007 mem_cmd_header_i / _v_i / _ready_and_o  in/in/out  header_width_p/1/1  command header, ready-valid.
REQ-008 mem_cmd_data_i / _v_i / _ready_and_o  in/in/out  data_width_p/1/1  write data beats, ready-valid.
REQ-009 mem_resp_header_o / _v_o / _yumi_i  out/out/in  header_width_p/1/1  response header, valid-yumi.
REQ-010 mem_resp_data_o / _v_o / _yumi_i  out/out/in  data_width_p/1/1  read data beats, valid-yumi.

Function
REQ-011 SHALL use FSM states IDLE, WR_DATA, RESP_HDR, RD_FETCH, RD_SEND.
REQ-012 mem_cmd_header_ready_and_o SHALL be 1 only in IDLE; handshake latches header, derives beats = max(1, 2^size/8).
REQ-013 IDLE transitions: wr/uc_wr -> WR_DATA; rd/uc_rd -> RESP_HDR; any other opcode -> RESP_HDR, no data, no store effect.
REQ-014 WR_DATA: mem_cmd_data_ready_and_o=1; each handshake writes store same cycle; after last beat -> RESP_HDR.
REQ-015 Sub-dword writes (size<3) SHALL write only bytes selected by addr[2:0] and size; other bytes unchanged.
REQ-016 RESP_HDR: mem_resp_header_v_o=1, mem_resp_header_o = latched header unmodified; on yumi -> IDLE (write/other) or RD_FETCH (read).
REQ-017 RD_FETCH SHALL issue one synchronous array read; next cycle RD_SEND.
REQ-018 RD_SEND: mem_resp_data_v_o=1, data held stable until yumi; on yumi -> RD_FETCH if beats remain, else IDLE.
REQ-019 Reads SHALL return full aligned dword regardless of size.
REQ-020 Word index = addr[3 +: log2(mem_els_p)], incremented per beat, wrapping within the size-aligned block (critical-word-first).
REQ-021 Index above mem_els_p-1 SHALL wrap modulo mem_els_p when bounds check is absent.
REQ-022 Beat counter SHALL be log2(17) bits; max 16 beats (128 B).
REQ-023 yumi_i asserted while the corresponding v_o is 0 SHALL be ignored.

Reset
REQ-024 On reset_i: state IDLE, counters 0, all v_o 0, mem_cmd_header_ready_and_o 1 after release, mem_cmd_data_ready_and_o 0.
REQ-025 Reset mid-transaction SHALL abandon it; no response emitted; store contents undefined-but-unchanged except beats already written.
REQ-026 Store contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro BP_STREAM_MEM_BOUNDS_CHECK_EN defined: address >= mem_els_p*8 drops writes, returns all-ones read beats; header still echoed.
REQ-028 Macro undefined: no check, modulo wrap per REQ-021; identical timing either way.

Structure
REQ-029 stream_mem_pkg SHALL hold header struct (msg_type[3:0], addr, size[2:0], payload), opcode enum (rd=0, wr=1, uc_rd=2, uc_wr=3), size enum.
REQ-030 Storage SHALL be one sub-module bp_stream_mem_array: 1rw synchronous read, byte-mask write, mem_els_p x data_width_p.

Verification
REQ-031 uc_wr size=3 addr 0x40 data 0xDEADBEEF_CAFEF00D, then uc_rd same addr -> header echoed, one beat 0xDEADBEEF_CAFEF00D.
REQ-032 wr size=6 addr 0x100 beats 0..7 = i, rd size=6 addr 0x118 -> beats 3,4,5,6,7,0,1,2.
REQ-033 uc_wr size=0 addr 0x43 data 0xAA over dword 0 -> rd 0x40 returns 0x00000000_AA000000.
REQ-034 rd with mem_resp_data_yumi_i withheld 10 cycles -> data_o stable, v_o held, no extra beats.
REQ-035 reset_i asserted after 3 of 8 write beats -> all v_o 0 next cycle, IDLE, next command served normally.
REQ-036 With BOUNDS_CHECK_EN, rd addr mem_els_p*8 -> 0xFFFFFFFF_FFFFFFFF; without, returns dword 0.
